// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
//   Request/response bundle between the EX stage and the iterative RV32M/RV64M
//   multiply/divide unit.
//
//   Signals (requester -> unit):
//     Start   request pulse, taken only when the unit is idle or finishing
//     Funct3  M-extension operation select
//     SrcA    rs1 operand (multiplicand / dividend)
//     SrcB    rs2 operand (multiplier / divisor)
//     Flush   abort the operation in flight
//   Signals (unit -> requester):
//     Busy    high while the unit is iterating or fixing up signs
//     Done    one-cycle completion pulse
//     Result  final value, held until the next accepted request
//
//   Modports: master = requester side (EX stage / bench), slave = unit side.
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            Flush;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, Funct3, SrcA, SrcB, Flush,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Funct3, SrcA, SrcB, Flush,
        output Busy, Done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the M extension. Operands are converted
//   to magnitudes at acceptance, a radix-2 shift-add multiply or restoring
//   divide runs for XLEN cycles, then a single fix-up cycle restores the sign
//   and selects the requested half / quotient / remainder.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset (clears everything, Result = 0)
//     bus    muldiv_unit_if.slave: Start, Funct3, SrcA, SrcB, Flush in;
//            Busy, Done, Result out
//
//   Optional feature macro: MULDIV_EARLY_OUT_EN
//     When defined, divide-by-zero, signed MIN / -1 and multiplies with a zero
//     operand finish straight from the accept edge (IDLE/DONE -> DONE).
//     When undefined, those cases take the normal XLEN+1-cycle path and give
//     the same values.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              negRes_q, negRes_d;
    logic              negRem_q, negRem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              signA, signB, isDivIn, accept;
    logic [XLEN-1:0]   absA, absB;

    logic [XLEN:0]     mulSum, divShift;
    logic [XLEN-1:0]   divRem;
    logic              divFits;
    logic [2*XLEN-1:0] mulNext, divNext, prodFix;
    logic [XLEN-1:0]   quoFix, remFix, fixVal;

    // Operand decode for the accept edge. Only the signed operand positions
    // contribute a sign; the magnitudes feed the unsigned iteration core.
    always_comb begin
        signA = 1'b0;
        signB = 1'b0;
        case (bus.Funct3)
            F_MULH, F_DIV, F_REM: begin
                signA = bus.SrcA[XLEN-1];
                signB = bus.SrcB[XLEN-1];
            end
            F_MULHSU: signA = bus.SrcA[XLEN-1];
            default: ;
        endcase
        absA    = signA ? -bus.SrcA : bus.SrcA;
        absB    = signB ? -bus.SrcB : bus.SrcB;
        isDivIn = bus.Funct3[2];
        accept  = bus.Start && !bus.Flush && (state_q == IDLE || state_q == DONE);
    end

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic            earlyHit;
    logic [XLEN-1:0] earlyVal;

    // Cases whose answer is known from the operands alone; REM* results
    // come from Funct3[1], signed DIV/REM from Funct3[0] == 0.
    always_comb begin
        earlyHit = 1'b0;
        earlyVal = '0;
        if (isDivIn && bus.SrcB == '0) begin
            earlyHit = 1'b1;
            earlyVal = bus.Funct3[1] ? bus.SrcA : '1;
        end else if (isDivIn && !bus.Funct3[0] && bus.SrcA == MIN_VAL && bus.SrcB == '1) begin
            earlyHit = 1'b1;
            earlyVal = bus.Funct3[1] ? '0 : MIN_VAL;
        end else if (!isDivIn && (bus.SrcA == '0 || bus.SrcB == '0)) begin
            earlyHit = 1'b1;
            earlyVal = '0;
        end
    end
`endif

    // One iteration of each algorithm. The 2*XLEN accumulator holds
    // {partial product, remaining multiplier bits} for multiply and
    // {partial remainder, remaining dividend / quotient bits} for divide.
    // The remainder subtraction is done in XLEN bits because a successful
    // trial always leaves a value below the divisor.
    always_comb begin
        mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mulNext  = {mulSum, acc_q[XLEN-1:1]};
        divShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        divFits  = divShift >= {1'b0, opnd_q};
        divRem   = divShift[XLEN-1:0] - opnd_q;
        divNext  = divFits ? {divRem, acc_q[XLEN-2:0], 1'b1}
                           : {divShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Sign restoration and result selection for the FIX cycle. The
    // remainder always takes the dividend's sign.
    always_comb begin
        prodFix = negRes_q ? -acc_q : acc_q;
        quoFix  = negRes_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remFix  = negRem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fixVal  = remFix;
        case (op_q)
            F_MUL:                     fixVal = prodFix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fixVal = prodFix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             fixVal = quoFix;
            F_REM, F_REMU:             fixVal = remFix;
            default: ;
        endcase
    end

    // Next-state logic. DONE lasts one cycle and can accept a new request
    // directly. A zero divisor must not flip the all-ones quotient, so the
    // result sign is suppressed in that case. Flush overrides everything
    // except reset and leaves Result alone.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d     = bus.Funct3;
                    opnd_d   = isDivIn ? absB : absA;
                    acc_d    = {{XLEN{1'b0}}, (isDivIn ? absA : absB)};
                    negRes_d = (signA ^ signB) && !(isDivIn && bus.SrcB == '0);
                    negRem_d = signA;
                    cnt_d    = '0;
                    state_d  = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (earlyHit) begin
                        state_d  = DONE;
                        result_d = earlyVal;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = op_q[2] ? divNext : mulNext;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fixVal;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.Flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.Busy   = (state_q == CALC) || (state_q == FIX);
    assign bus.Done   = (state_q == DONE);
    assign bus.Result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (XLEN = 32). Each request pushes its
//   reference result and expected latency (edges from the accept edge to the
//   first cycle with Done high) onto a queue; entries are popped when Done
//   is seen. Scenario tasks run in sequence from one initial block.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam int XLEN = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;
    localparam logic [31:0] MIN32   = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic  clk;
    logic  reset;
    exp_t  sbQ[$];
    int    vecCount  = 0;
    int    missCount = 0;
    logic [31:0] lastResult = '0;

    muldiv_unit_if #(.XLEN(XLEN)) mdIf ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mdIf)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model written directly from the RISC-V M definitions.
    function automatic logic [31:0] refResult(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = int'(a);
        sb = int'(b);
        case (f3)
            F_MUL:    begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            F_MULH:   begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            F_MULHSU: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
            F_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            F_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
                return 32'(sa / sb);
            end
            F_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 32'd0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default:  return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        bit early;
        early = (f3[2] && b == 32'd0) ||
                ((f3 == F_DIV || f3 == F_REM) && a == MIN32 && b == 32'hFFFF_FFFF) ||
                (!f3[2] && (a == 32'd0 || b == 32'd0));
        return (EARLY_EN && early) ? 0 : XLEN + 1;
    endfunction

    // Drive one request through its accept edge, push the expectation, then
    // scramble the operand inputs so late sampling would be noticed.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = refResult(f3, a, b);
        e.lat = refLatency(f3, a, b);
        sbQ.push_back(e);
        mdIf.Funct3 = f3;
        mdIf.SrcA   = a;
        mdIf.SrcB   = b;
        mdIf.Start  = 1'b1;
        @(posedge clk);
        #1;
        mdIf.Start  = 1'b0;
        mdIf.SrcA   = $urandom;
        mdIf.SrcB   = $urandom;
        mdIf.Funct3 = 3'($urandom_range(0, 7));
    endtask

    // Count edges until Done, noting any waiting cycle with Busy low.
    task automatic waitDone(output int edges, output int busyGaps, output bit timedOut);
        edges    = 0;
        busyGaps = 0;
        timedOut = 1'b0;
        while (mdIf.Done !== 1'b1) begin
            if (mdIf.Busy !== 1'b1) busyGaps++;
            if (edges >= 100) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        vecCount++;
        if (mdIf.Busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy got %b want 0", mdIf.Busy); end
        vecCount++;
        if (mdIf.Done !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done got %b want 0", mdIf.Done); end
        vecCount++;
        if (mdIf.Result !== 32'd0) begin missCount++; $display("[TB] FAIL reset_result got %h want 0", mdIf.Result); end
    endtask

    // Runs a table of operations one at a time, checking value, latency and
    // Busy behaviour for each.
    task automatic test_mul();
        logic [2:0]  f3s[6] = '{F_MUL, F_MULH, F_MULHU, F_MULHSU, F_MULH, F_MUL};
        logic [31:0] as[6]  = '{32'd7, MIN32, MIN32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] bs[6]  = '{32'hFFFF_FFFD, MIN32, MIN32, 32'd2, 32'h7FFF_FFFF, 32'h9ABC_DEF0};
        int edges, gaps;
        bit tmo;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(f3s[i], as[i], bs[i]);
            waitDone(edges, gaps, tmo);
            e = sbQ.pop_front();
            vecCount++;
            if (tmo) begin
                missCount++;
                $display("[TB] FAIL mul[%0d] done_timeout got none want done after %0d edges", i, e.lat);
            end else begin
                if (mdIf.Result !== e.res) begin missCount++; $display("[TB] FAIL mul[%0d] result got %h want %h", i, mdIf.Result, e.res); end
                vecCount++;
                if (edges !== e.lat) begin missCount++; $display("[TB] FAIL mul[%0d] latency got %0d want %0d", i, edges, e.lat); end
                vecCount++;
                if (gaps !== 0 || mdIf.Busy !== 1'b0) begin missCount++; $display("[TB] FAIL mul[%0d] busy gaps=%0d busy_at_done=%b want 0/0", i, gaps, mdIf.Busy); end
            end
            lastResult = e.res;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s[6] = '{F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM};
        logic [31:0] as[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs[6]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        int edges, gaps;
        bit tmo;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(f3s[i], as[i], bs[i]);
            waitDone(edges, gaps, tmo);
            e = sbQ.pop_front();
            vecCount++;
            if (tmo) begin
                missCount++;
                $display("[TB] FAIL div[%0d] done_timeout got none want done after %0d edges", i, e.lat);
            end else begin
                if (mdIf.Result !== e.res) begin missCount++; $display("[TB] FAIL div[%0d] result got %h want %h", i, mdIf.Result, e.res); end
                vecCount++;
                if (edges !== e.lat) begin missCount++; $display("[TB] FAIL div[%0d] latency got %0d want %0d", i, edges, e.lat); end
            end
            lastResult = e.res;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s[8] = '{F_DIV, F_REM, F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_MUL};
        logic [31:0] as[8]  = '{32'd5, 32'd5, MIN32, MIN32, 32'hFFFF_FFF0, 32'd9, 32'hFFFF_FFFB, 32'd0};
        logic [31:0] bs[8]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h1234};
        int edges, gaps;
        bit tmo;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(f3s[i], as[i], bs[i]);
            waitDone(edges, gaps, tmo);
            e = sbQ.pop_front();
            vecCount++;
            if (tmo) begin
                missCount++;
                $display("[TB] FAIL special[%0d] done_timeout got none want done after %0d edges", i, e.lat);
            end else begin
                if (mdIf.Result !== e.res) begin missCount++; $display("[TB] FAIL special[%0d] result got %h want %h", i, mdIf.Result, e.res); end
                vecCount++;
                if (edges !== e.lat) begin missCount++; $display("[TB] FAIL special[%0d] latency got %0d want %0d", i, edges, e.lat); end
            end
            lastResult = e.res;
        end
    endtask

    // Flush (together with a competing Start) on the tenth cycle of a divide.
    task automatic test_flush();
        int doneSeen = 0;
        int edges, gaps;
        bit tmo;
        exp_t e;
        applyStimulus(F_DIV, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        mdIf.Flush  = 1'b1;
        mdIf.Start  = 1'b1;
        mdIf.Funct3 = F_MUL;
        mdIf.SrcA   = 32'd3;
        mdIf.SrcB   = 32'd4;
        @(posedge clk);
        #1;
        mdIf.Flush = 1'b0;
        mdIf.Start = 1'b0;
        void'(sbQ.pop_back());
        vecCount++;
        if (mdIf.Busy !== 1'b0) begin missCount++; $display("[TB] FAIL flush_busy got %b want 0", mdIf.Busy); end
        vecCount++;
        if (mdIf.Done !== 1'b0) begin missCount++; $display("[TB] FAIL flush_done got %b want 0", mdIf.Done); end
        vecCount++;
        if (mdIf.Result !== lastResult) begin missCount++; $display("[TB] FAIL flush_result got %h want %h", mdIf.Result, lastResult); end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mdIf.Done === 1'b1 || mdIf.Busy === 1'b1) doneSeen++;
        end
        vecCount++;
        if (doneSeen !== 0) begin missCount++; $display("[TB] FAIL flush_quiet got %0d active cycles want 0", doneSeen); end

        applyStimulus(F_DIVU, 32'd100, 32'd7);
        waitDone(edges, gaps, tmo);
        e = sbQ.pop_front();
        vecCount++;
        if (tmo || mdIf.Result !== e.res || edges !== e.lat) begin
            missCount++;
            $display("[TB] FAIL flush_restart got %h after %0d edges want %h after %0d", mdIf.Result, edges, e.res, e.lat);
        end
        lastResult = e.res;
    endtask

    // A Start pulse in the middle of a multiply must not disturb it.
    task automatic test_busy_ignore();
        int extra = 0;
        int edges, gaps;
        bit tmo;
        exp_t e;
        applyStimulus(F_MUL, 32'd7, 32'hFFFF_FFFD);
        repeat (5) begin @(posedge clk); #1; end
        mdIf.Funct3 = F_DIVU;
        mdIf.SrcA   = 32'd100;
        mdIf.SrcB   = 32'd7;
        mdIf.Start  = 1'b1;
        @(posedge clk);
        #1;
        mdIf.Start  = 1'b0;
        waitDone(edges, gaps, tmo);
        e = sbQ.pop_front();
        vecCount++;
        if (tmo || mdIf.Result !== e.res) begin missCount++; $display("[TB] FAIL ignore_result got %h want %h", mdIf.Result, e.res); end
        vecCount++;
        if (edges + 6 !== e.lat) begin missCount++; $display("[TB] FAIL ignore_latency got %0d want %0d", edges + 6, e.lat); end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mdIf.Done === 1'b1) extra++;
        end
        vecCount++;
        if (extra !== 0) begin missCount++; $display("[TB] FAIL ignore_extra_done got %0d want 0", extra); end
        lastResult = e.res;
    endtask

    // Second request issued in the DONE cycle of the first.
    task automatic test_back_to_back();
        int edges, gaps;
        bit tmo;
        exp_t e;
        applyStimulus(F_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        waitDone(edges, gaps, tmo);
        e = sbQ.pop_front();
        vecCount++;
        if (tmo || mdIf.Result !== e.res) begin missCount++; $display("[TB] FAIL b2b_first got %h want %h", mdIf.Result, e.res); end
        applyStimulus(F_REMU, 32'hDEAD_BEEF, 32'd1000);
        waitDone(edges, gaps, tmo);
        e = sbQ.pop_front();
        vecCount++;
        if (tmo || mdIf.Result !== e.res) begin missCount++; $display("[TB] FAIL b2b_second got %h want %h", mdIf.Result, e.res); end
        vecCount++;
        if (edges !== e.lat) begin missCount++; $display("[TB] FAIL b2b_latency got %0d want %0d", edges, e.lat); end
        lastResult = e.res;
    endtask

    // Reset in the middle of a multiply, then one recovery operation.
    task automatic test_reset_midop();
        int edges, gaps;
        bit tmo;
        exp_t e;
        applyStimulus(F_MUL, 32'd123, 32'd456);
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbQ.delete();
        lastResult = '0;
        vecCount++;
        if (mdIf.Busy !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_busy got %b want 0", mdIf.Busy); end
        vecCount++;
        if (mdIf.Done !== 1'b0) begin missCount++; $display("[TB] FAIL midreset_done got %b want 0", mdIf.Done); end
        vecCount++;
        if (mdIf.Result !== 32'd0) begin missCount++; $display("[TB] FAIL midreset_result got %h want 0", mdIf.Result); end
        applyStimulus(F_MUL, 32'd6, 32'd7);
        waitDone(edges, gaps, tmo);
        e = sbQ.pop_front();
        vecCount++;
        if (tmo || mdIf.Result !== e.res || edges !== e.lat) begin
            missCount++;
            $display("[TB] FAIL midreset_recover got %h after %0d edges want %h after %0d", mdIf.Result, edges, e.res, e.lat);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset       = 1'b1;
        mdIf.Start  = 1'b0;
        mdIf.Flush  = 1'b0;
        mdIf.Funct3 = '0;
        mdIf.SrcA   = '0;
        mdIf.SrcB   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
